aes_round_ctrl: RTL
===================

// Module: aes_round_ctrl
// PURPOSE
//  Round sequencer for the AES encrypt datapath: drives the per-round stage enables
//  (SubBytes, ShiftRows, MixColumns, AddRoundKey), the round index and the state-register write.
//  Sits between the input/output handshakes and the round datapath.
//  Stalls on the key-expansion valid; holds no plaintext/ciphertext data itself.
// PARAMETERS
//  NR   10  number of rounds (10/12/14 for AES-128/192/256)
//  RW   4   width of round index; must hold NR
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   reset, asynchronous, active-high
//  in_valid   in   1   plaintext block available
//  in_ready   out  1   controller can accept a block (comb. from state)
//  ld_in      out  1   datapath captures plaintext this cycle (= in_valid & in_ready)
//  key_valid  in   1   round key for index round is available
//  abort      in   1   synchronous abandon of the block in flight
//  round      out  RW  current round index = round-key index
//  ark_en     out  1   AddRoundKey enable
//  sub_en     out  1   SubBytes enable
//  shift_en   out  1   ShiftRows enable
//  mix_en     out  1   MixColumns enable
//  state_we   out  1   datapath state register write enable
//  busy       out  1   state is INIT, ROUND or FINAL
//  out_valid  out  1   ciphertext in datapath register is final
//  out_ready  in   1   consumer takes ciphertext
// BEHAVIOUR
//  Reset: asynchronous, active-high; FSM=IDLE, round=0.
//   Outputs: in_ready=1, out_valid=0, all enables=0, state_we=0, ld_in=0, busy=0.
//  Reset mid-operation: outputs take reset values immediately; the block is dropped.
//  States:
//   IDLE:  in_ready=1. Accept -> INIT.
//   INIT:  round=0; ark_en=1 only.
//   ROUND: round=1..NR-1; sub/shift/mix/ark=1.
//   FINAL: round=NR; sub/shift/ark=1, mix_en=0.
//   DONE:  out_valid=1; in_ready=out_ready.
//   Enables are 0 in IDLE and DONE.
//  Progress: in INIT/ROUND/FINAL, state_we=key_valid.
//   If key_valid=1: the stage completes. INIT->ROUND (round=1); ROUND round++;
//    ROUND with round=NR-1 -> FINAL; FINAL->DONE.
//   If key_valid=0: state and round hold; enables stay driven; state_we=0.
//  Latency, no stalls: accept in cycle 0, INIT in cycle 1, round r in cycle r+1,
//   out_valid in cycle NR+2.
//  DONE: out_valid stays high until out_ready.
//   out_ready=1, in_valid=0 -> IDLE.
//   out_ready=1, in_valid=1 -> ld_in=1, go straight to INIT (back-to-back, one block per NR+2 cycles).
//   out_ready=0: in_valid is ignored; ld_in=0.
//  abort: priority over progress in INIT/ROUND/FINAL -> IDLE next cycle, round=0, no out_valid.
//   Ignored in IDLE and DONE.
//  round never exceeds NR; no wrap. An illegal FSM encoding recovers to IDLE.
//  Outputs are registered or decoded from registered state; no comb. path
//   from key_valid/in_valid to round.
// TESTING
//  1 NR=10, reset, in_valid pulse cycle 0, key_valid=1, out_ready=1 -> ld_in@0; round 0..10 @1..11;
//    mix_en=0 @11; out_valid @12 for 1 cycle.
//  2 key_valid=0 for 3 cycles while round=5 -> round holds 5, state_we=0; out_valid @15.
//  3 out_ready=0 for 4 cycles in DONE with in_valid=1 -> out_valid held, in_ready=0, ld_in=0;
//    release -> accept same cycle.
//  4 Two back-to-back blocks -> second ld_in in first block's DONE cycle; out_valid @12 and @24.
//  5 rst asserted asynchronously mid-clock while round=6 -> busy=0, enables=0, round=0 before next
//    edge; FSM=IDLE after release.
//  6 abort in FINAL -> IDLE next cycle, no out_valid. NR=14 build, no stalls -> out_valid @16.

Source files
------------

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// aes_round_ctrl: round sequencer for the AES encrypt datapath.
// Drives stage enables, round-key index and state write; stalls on key_valid.
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ld_in,
  input  logic          key_valid,
  input  logic          abort,
  output logic [RW-1:0] round,
  output logic          ark_en,
  output logic          sub_en,
  output logic          shift_en,
  output logic          mix_en,
  output logic          state_we,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [RW-1:0] LAST_MID = RW'(NR - 1);
  localparam logic [RW-1:0] ROUND_NR = RW'(NR);

  state_t        state;
  state_t        state_d;
  logic [RW-1:0] round_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      round <= '0;
    end else begin
      state <= state_d;
      round <= round_d;
    end
  end

  always_comb begin
    state_d   = state;
    round_d   = round;
    in_ready  = 1'b0;
    ark_en    = 1'b0;
    sub_en    = 1'b0;
    shift_en  = 1'b0;
    mix_en    = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_INIT;
          round_d = '0;
        end
      end
      S_INIT: begin
        busy   = 1'b1;
        ark_en = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
          round_d = '0;
        end else if (key_valid) begin
          state_d = S_ROUND;
          round_d = RW'(1);
        end
      end
      S_ROUND: begin
        busy     = 1'b1;
        ark_en   = 1'b1;
        sub_en   = 1'b1;
        shift_en = 1'b1;
        mix_en   = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
          round_d = '0;
        end else if (key_valid) begin
          round_d = round + RW'(1);
          if (round == LAST_MID) begin
            state_d = S_FINAL;
            round_d = ROUND_NR;
          end
        end
      end
      S_FINAL: begin
        busy     = 1'b1;
        ark_en   = 1'b1;
        sub_en   = 1'b1;
        shift_en = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
          round_d = '0;
        end else if (key_valid) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Ciphertext is held until taken; a waiting block may be accepted in the same cycle.
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          round_d = '0;
          state_d = in_valid ? S_INIT : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase
  end

  assign ld_in    = in_valid & in_ready;
  assign state_we = busy & key_valid;

endmodule
`default_nettype wire
